// File: rtl/collision_event_manager.sv
// Folds per-pixel collision strobes into sticky per-frame events and, on each
// frame boundary, advances score, lives, level and the top-level game state.
module collision_event_manager #(
   parameter int INIT_LIVES      = 3,
   parameter int POINTS_PER_KILL = 10,
   parameter int SCORE_MAX       = 9999,
   parameter int INVULN_FRAMES   = 60,
   parameter int CLEAR_FRAMES    = 90,
   parameter int MAX_LEVEL       = 7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        startOfFrame,
   input  logic        startGame,
   input  logic [1:0]  alienHit,
   input  logic        playerHitByAlienPulse,
   input  logic [2:0]  playerHitByRocket,
   input  logic        aliensReachedBorder,
   input  logic        aliensCleared,
   output logic [2:0]  gameState,
   output logic [13:0] score,
   output logic [1:0]  lives,
   output logic [2:0]  level,
   output logic        playerInvulnerable,
   output logic        playerExplodePulse,
   output logic        levelUpPulse,
   output logic        restartPulse
);

   localparam int CNT_MAX = (INVULN_FRAMES > CLEAR_FRAMES) ? INVULN_FRAMES : CLEAR_FRAMES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_PLAYING     = 3'd1,
      S_HIT         = 3'd2,
      S_LEVEL_CLEAR = 3'd3,
      S_GAME_OVER   = 3'd4
   } state_t;

   state_t             r_state, w_state;
   logic [13:0]        r_score, w_score;
   logic [1:0]         r_lives, w_lives;
   logic [2:0]         r_level, w_level;
   logic [CNT_W-1:0]   r_frame_cnt, w_frame_cnt;
   logic [1:0]         r_kill_flag, w_kill_flag;
   logic               r_hit_flag, w_hit_flag;
   logic               r_border_flag, w_border_flag;
   logic               r_invuln, w_invuln;
   logic               r_explode, w_explode;
   logic               r_level_up, w_level_up;
   logic               r_restart, w_restart;
   logic [1:0]         w_kills;
   logic               w_hit_now;

   // Sum is formed one bit wider than the score so the ceiling compare cannot wrap.
   function automatic logic [13:0] sat_score(input logic [13:0] cur, input logic [1:0] kills);
      logic [14:0] sum;
      sum = {1'b0, cur} + (15'(kills) * 15'(POINTS_PER_KILL));
      if (sum > 15'(SCORE_MAX)) return 14'(SCORE_MAX);
      return sum[13:0];
   endfunction

   function automatic logic [2:0] sat_level(input logic [2:0] cur);
      if (cur >= 3'(MAX_LEVEL)) return 3'(MAX_LEVEL);
      return cur + 3'd1;
   endfunction

   function automatic logic [1:0] dec_lives(input logic [1:0] cur);
      if (cur == 2'd0) return 2'd0;
      return cur - 2'd1;
   endfunction

   assign w_kills   = {1'b0, r_kill_flag[1]} + {1'b0, r_kill_flag[0]};
   assign w_hit_now = (|playerHitByRocket) | playerHitByAlienPulse;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_score       <= '0;
         r_lives       <= '0;
         r_level       <= 3'd1;
         r_frame_cnt   <= '0;
         r_kill_flag   <= '0;
         r_hit_flag    <= 1'b0;
         r_border_flag <= 1'b0;
         r_invuln      <= 1'b0;
         r_explode     <= 1'b0;
         r_level_up    <= 1'b0;
         r_restart     <= 1'b0;
      end else begin
         r_state       <= w_state;
         r_score       <= w_score;
         r_lives       <= w_lives;
         r_level       <= w_level;
         r_frame_cnt   <= w_frame_cnt;
         r_kill_flag   <= w_kill_flag;
         r_hit_flag    <= w_hit_flag;
         r_border_flag <= w_border_flag;
         r_invuln      <= w_invuln;
         r_explode     <= w_explode;
         r_level_up    <= w_level_up;
         r_restart     <= w_restart;
      end
   end

   always_comb begin
      w_state     = r_state;
      w_score     = r_score;
      w_lives     = r_lives;
      w_level     = r_level;
      w_frame_cnt = r_frame_cnt;
      w_explode   = 1'b0;
      w_level_up  = 1'b0;
      w_restart   = 1'b0;

      // Frame boundary reloads the flags so an event in the SOF cycle belongs to the new frame.
      if (startOfFrame) begin
         w_kill_flag   = alienHit;
         w_hit_flag    = w_hit_now;
         w_border_flag = aliensReachedBorder;
      end else begin
         w_kill_flag   = r_kill_flag | alienHit;
         w_hit_flag    = r_hit_flag | w_hit_now;
         w_border_flag = r_border_flag | aliensReachedBorder;
      end

      case (r_state)
         S_IDLE, S_GAME_OVER: begin
            if (startGame) begin
               w_state     = S_PLAYING;
               w_score     = '0;
               w_lives     = 2'(INIT_LIVES);
               w_level     = 3'd1;
               w_frame_cnt = '0;
               w_restart   = 1'b1;
            end
         end
         S_PLAYING: begin
            if (startOfFrame) begin
               w_score = sat_score(r_score, w_kills);
               if (r_border_flag) begin
                  w_lives = 2'd0;
                  w_state = S_GAME_OVER;
               end else if (r_hit_flag) begin
                  w_lives   = dec_lives(r_lives);
                  w_explode = 1'b1;
                  if (dec_lives(r_lives) == 2'd0) begin
                     w_state = S_GAME_OVER;
                  end else begin
                     w_state     = S_HIT;
                     w_frame_cnt = CNT_W'(INVULN_FRAMES);
                  end
               end else if (aliensCleared) begin
                  w_state     = S_LEVEL_CLEAR;
                  w_frame_cnt = CNT_W'(CLEAR_FRAMES);
               end
            end
         end
         S_HIT: begin
            if (startOfFrame) begin
               w_score = sat_score(r_score, w_kills);
               if (r_border_flag) begin
                  w_lives = 2'd0;
                  w_state = S_GAME_OVER;
               end else if (r_frame_cnt <= CNT_W'(1)) begin
                  w_frame_cnt = '0;
                  w_state     = S_PLAYING;
               end else begin
                  w_frame_cnt = r_frame_cnt - CNT_W'(1);
               end
            end
         end
         S_LEVEL_CLEAR: begin
            if (startOfFrame) begin
               w_score = sat_score(r_score, w_kills);
               if (r_frame_cnt <= CNT_W'(1)) begin
                  w_frame_cnt = '0;
                  w_level     = sat_level(r_level);
                  w_level_up  = 1'b1;
                  w_state     = S_PLAYING;
               end else begin
                  w_frame_cnt = r_frame_cnt - CNT_W'(1);
               end
            end
         end
         default: w_state = S_IDLE;
      endcase

      w_invuln = (w_state == S_HIT);
   end

   assign gameState          = r_state;
   assign score              = r_score;
   assign lives              = r_lives;
   assign level              = r_level;
   assign playerInvulnerable = r_invuln;
   assign playerExplodePulse = r_explode;
   assign levelUpPulse       = r_level_up;
   assign restartPulse       = r_restart;

endmodule

// File: tb/tb_collision_event_manager.sv
// Scoreboard bench: stimulus queues expected output snapshots tagged with the
// cycle they are due; a negedge monitor pops and compares them.
module tb_collision_event_manager;

   logic        clk = 1'b0;
   logic        reset;
   logic        startOfFrame;
   logic        startGame;
   logic [1:0]  alienHit;
   logic        playerHitByAlienPulse;
   logic [2:0]  playerHitByRocket;
   logic        aliensReachedBorder;
   logic        aliensCleared;
   logic [2:0]  gameState;
   logic [13:0] score;
   logic [1:0]  lives;
   logic [2:0]  level;
   logic        playerInvulnerable;
   logic        playerExplodePulse;
   logic        levelUpPulse;
   logic        restartPulse;

   always #5 clk = ~clk;

   collision_event_manager dut (
      .clk                   (clk),
      .reset                 (reset),
      .startOfFrame          (startOfFrame),
      .startGame             (startGame),
      .alienHit              (alienHit),
      .playerHitByAlienPulse (playerHitByAlienPulse),
      .playerHitByRocket     (playerHitByRocket),
      .aliensReachedBorder   (aliensReachedBorder),
      .aliensCleared         (aliensCleared),
      .gameState             (gameState),
      .score                 (score),
      .lives                 (lives),
      .level                 (level),
      .playerInvulnerable    (playerInvulnerable),
      .playerExplodePulse    (playerExplodePulse),
      .levelUpPulse          (levelUpPulse),
      .restartPulse          (restartPulse)
   );

   typedef struct {
      int          due;
      string       nm;
      logic [2:0]  gs;
      logic [13:0] sc;
      logic [1:0]  lv;
      logic [2:0]  lev;
      logic        inv;
      logic [2:0]  pul;   // {explode, levelUp, restart}
   } exp_t;

   exp_t q[$];
   exp_t m_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (q.size() > 0 && q[0].due < cyc) begin
         m_e = q.pop_front();
         checks++;
         errors++;
         $display("FAIL %s: never sampled (due cycle %0d, now %0d)", m_e.nm, m_e.due, cyc);
      end else if (q.size() > 0 && q[0].due == cyc) begin
         m_e = q.pop_front();
         checks++;
         if ({gameState, score, lives, level, playerInvulnerable,
              playerExplodePulse, levelUpPulse, restartPulse} !==
             {m_e.gs, m_e.sc, m_e.lv, m_e.lev, m_e.inv, m_e.pul}) begin
            errors++;
            $display("FAIL %s: got gs=%0d sc=%0d lv=%0d lev=%0d inv=%0b pul=%b, want gs=%0d sc=%0d lv=%0d lev=%0d inv=%0b pul=%b",
                     m_e.nm, gameState, score, lives, level, playerInvulnerable,
                     {playerExplodePulse, levelUpPulse, restartPulse},
                     m_e.gs, m_e.sc, m_e.lv, m_e.lev, m_e.inv, m_e.pul);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected outputs after the coming clock edge.
   task automatic push_exp(input string nm, input logic [2:0] gs, input logic [13:0] sc,
                           input logic [1:0] lv, input logic [2:0] lev, input logic [2:0] pul);
      exp_t e;
      e.due = cyc + 1;
      e.nm  = nm;
      e.gs  = gs;
      e.sc  = sc;
      e.lv  = lv;
      e.lev = lev;
      e.inv = (gs == 3'd2);
      e.pul = pul;
      q.push_back(e);
   endtask

   // One frame: an event cycle, the SOF cycle (checked), and a hold cycle (pulses must drop).
   task automatic frame(input logic [1:0] pre_ah, input logic [2:0] pre_pr, input logic pre_ap,
                        input logic [1:0] sof_ah, input logic ac, input string nm,
                        input logic [2:0] gs, input logic [13:0] sc, input logic [1:0] lv,
                        input logic [2:0] lev, input logic [2:0] pul);
      alienHit              = pre_ah;
      playerHitByRocket     = pre_pr;
      playerHitByAlienPulse = pre_ap;
      step();
      alienHit              = sof_ah;
      playerHitByRocket     = 3'b000;
      playerHitByAlienPulse = 1'b0;
      aliensCleared         = ac;
      startOfFrame          = 1'b1;
      push_exp(nm, gs, sc, lv, lev, pul);
      step();
      startOfFrame  = 1'b0;
      alienHit      = 2'b00;
      aliensCleared = 1'b0;
      push_exp({nm, "_hold"}, gs, sc, lv, lev, 3'b000);
      step();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_sc;
      reset                 = 1'b1;
      startOfFrame          = 1'b0;
      startGame             = 1'b0;
      alienHit              = 2'b00;
      playerHitByAlienPulse = 1'b0;
      playerHitByRocket     = 3'b000;
      aliensReachedBorder   = 1'b0;
      aliensCleared         = 1'b0;
      step();
      step();
      push_exp("reset", 3'd0, 14'd0, 2'd0, 3'd1, 3'b000);
      step();
      reset = 1'b0;
      step();

      startGame = 1'b1;
      push_exp("start", 3'd1, 14'd0, 2'd3, 3'd1, 3'b001);
      step();
      startGame = 1'b0;
      push_exp("restart_one_cycle", 3'd1, 14'd0, 2'd3, 3'd1, 3'b000);
      step();

      // Kills are sticky per frame: five cycles of double hit still score two kills.
      alienHit = 2'b11;
      repeat (5) step();
      alienHit = 2'b00;
      frame(2'b00, 3'b000, 1'b0, 2'b00, 1'b0, "kill_sticky", 3'd1, 14'd20, 2'd3, 3'd1, 3'b000);
      frame(2'b00, 3'b000, 1'b0, 2'b00, 1'b0, "no_kill", 3'd1, 14'd20, 2'd3, 3'd1, 3'b000);
      frame(2'b00, 3'b000, 1'b0, 2'b01, 1'b0, "sof_kill_deferred", 3'd1, 14'd20, 2'd3, 3'd1, 3'b000);
      frame(2'b00, 3'b000, 1'b0, 2'b00, 1'b0, "sof_kill_scored", 3'd1, 14'd30, 2'd3, 3'd1, 3'b000);

      startGame = 1'b1;
      push_exp("start_ignored_playing", 3'd1, 14'd30, 2'd3, 3'd1, 3'b000);
      step();
      startGame = 1'b0;

      frame(2'b00, 3'b100, 1'b0, 2'b00, 1'b0, "rocket_hit", 3'd2, 14'd30, 2'd2, 3'd1, 3'b100);
      for (int i = 0; i < 59; i++)
         frame(2'b00, 3'b010, 1'b0, 2'b00, 1'b0, "hit_invuln", 3'd2, 14'd30, 2'd2, 3'd1, 3'b000);
      frame(2'b00, 3'b000, 1'b0, 2'b00, 1'b0, "hit_exit", 3'd1, 14'd30, 2'd2, 3'd1, 3'b000);

      frame(2'b00, 3'b000, 1'b1, 2'b00, 1'b0, "alien_hit", 3'd2, 14'd30, 2'd1, 3'd1, 3'b100);
      for (int i = 0; i < 59; i++)
         frame(2'b00, 3'b000, 1'b0, 2'b00, 1'b0, "hit2_invuln", 3'd2, 14'd30, 2'd1, 3'd1, 3'b000);
      frame(2'b00, 3'b000, 1'b0, 2'b00, 1'b0, "hit2_exit", 3'd1, 14'd30, 2'd1, 3'd1, 3'b000);

      frame(2'b00, 3'b001, 1'b0, 2'b00, 1'b1, "hit_beats_clear", 3'd4, 14'd30, 2'd0, 3'd1, 3'b100);
      frame(2'b11, 3'b111, 1'b1, 2'b00, 1'b1, "gameover_frozen", 3'd4, 14'd30, 2'd0, 3'd1, 3'b000);

      startGame = 1'b1;
      push_exp("restart_from_gameover", 3'd1, 14'd0, 2'd3, 3'd1, 3'b001);
      step();
      startGame = 1'b0;
      push_exp("restart_hold", 3'd1, 14'd0, 2'd3, 3'd1, 3'b000);
      step();

      // Six clears climb from level 1 to 7; the seventh must hold at 7.
      for (int lv = 1; lv <= 7; lv++) begin
         frame(2'b00, 3'b000, 1'b0, 2'b00, 1'b1, "clear_enter", 3'd3, 14'd0, 2'd3, 3'(lv), 3'b000);
         for (int i = 0; i < 89; i++)
            frame(2'b00, 3'b100, 1'b0, 2'b00, 1'b0, "clear_wait", 3'd3, 14'd0, 2'd3, 3'(lv), 3'b000);
         frame(2'b00, 3'b000, 1'b0, 2'b00, 1'b0, "level_up", 3'd1, 14'd0, 2'd3,
               (lv < 7) ? 3'(lv + 1) : 3'd7, 3'b010);
      end

      exp_sc = 0;
      for (int i = 0; i < 499; i++) begin
         exp_sc += 20;
         frame(2'b11, 3'b000, 1'b0, 2'b00, 1'b0, "score_ramp", 3'd1, 14'(exp_sc), 2'd3, 3'd7, 3'b000);
      end
      frame(2'b01, 3'b000, 1'b0, 2'b00, 1'b0, "score_9990", 3'd1, 14'd9990, 2'd3, 3'd7, 3'b000);
      frame(2'b11, 3'b000, 1'b0, 2'b00, 1'b0, "score_saturate", 3'd1, 14'd9999, 2'd3, 3'd7, 3'b000);
      frame(2'b10, 3'b000, 1'b0, 2'b00, 1'b0, "score_stay_max", 3'd1, 14'd9999, 2'd3, 3'd7, 3'b000);

      playerHitByRocket = 3'b001;
      step();
      playerHitByRocket = 3'b000;
      startOfFrame = 1'b1;
      push_exp("hit_before_reset", 3'd2, 14'd9999, 2'd2, 3'd7, 3'b100);
      step();
      startOfFrame = 1'b0;
      reset = 1'b1;
      push_exp("reset_mid_hit", 3'd0, 14'd0, 2'd0, 3'd1, 3'b000);
      step();
      reset = 1'b0;
      push_exp("reset_hold", 3'd0, 14'd0, 2'd0, 3'd1, 3'b000);
      step();

      repeat (3) step();
      while (q.size() > 0) begin
         m_e = q.pop_front();
         checks++;
         errors++;
         $display("FAIL %s: left unchecked (due cycle %0d)", m_e.nm, m_e.due);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
